// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit: size encodings, FSM states,
// the registered request record and the alignment helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        is_unsigned;
  } req_t;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic size_e to_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mau_data_align.sv
// Combinational lane handling: load lane select with sign/zero extension, and
// store merge of the addressed byte/half lanes into the current memory word.
module mau_data_align
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = mem_word[{off, 3'b000} +: 8];
  assign lane_half = mem_word[{off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_data  = mem_word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = is_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        store_data = mem_word;
        store_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = is_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
        store_data = mem_word;
        store_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = mem_word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a 128-word memory with a combinational read port.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data
);

  state_e      state, state_next;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic [1:0]  lane_off;
  logic        trap;
  logic [31:0] load_data, store_data;

`ifdef MAU_MISALIGN_TRAP_EN
  logic err_q;
  assign lane_off = req_q.addr[1:0];
  assign trap     = is_misaligned(req_q.size, req_q.addr[1:0]);
  assign resp_err = err_q;
`else
  // Misaligned requests drop their offending offset bits and proceed normally.
  assign lane_off = align_off(req_q.size, req_q.addr[1:0]);
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  mau_data_align u_align (
    .size        (req_q.size),
    .off         (lane_off),
    .is_unsigned (req_q.is_unsigned),
    .mem_word    (mem_data),
    .wdata       (req_q.wdata),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (req_valid && req_ready) begin
        req_q <= '{we: req_we, size: to_size(req_size), addr: req_addr,
                   wdata: req_wdata, is_unsigned: req_unsigned};
      end
      if (state == ACCESS) begin
        rdata_q <= (req_q.we || trap) ? 32'h0 : load_data;
`ifdef MAU_MISALIGN_TRAP_EN
        err_q   <= trap;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so reset kills mem_we at once.
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_rdata  = rdata_q;
  assign mem_we      = (state == ACCESS) && req_q.we && !trap;
  assign mem_addr    = req_q.addr[8:2];
  assign mem_data_in = store_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 128-word memory.
// Expectations follow the build: MAU_MISALIGN_TRAP_EN selects the trapping variant.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data;

  logic [31:0] mem [128];
  int tests = 0;
  int fails = 0;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic [8:0] addr,
                           input logic [31:0] wdata, input logic uns);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_addr     = addr;
    req_wdata    = wdata;
    req_unsigned = uns;
  endtask

  // Full transaction: accept, wait (bounded) for the response, then consume it.
  task automatic transact(input string tag, input logic we, input logic [1:0] size,
                          input logic [8:0] addr, input logic [31:0] wdata, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_we);
    int lat;
    int we_cnt;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    drive_req(we, size, addr, wdata, uns);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    we_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
    end while (!resp_valid && lat < 8);
    check({tag, "_resp_seen"}, resp_valid, 1);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_we_cycles"}, we_cnt, exp_we);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, resp_err, exp_err);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, "_done"}, resp_valid, 0);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    #3;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load back.
    transact("st_word", 1'b1, 2'b10, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1);
    check("st_word_mem", mem[4], 32'hDEADBEEF);
    transact("ld_word", 1'b0, 2'b10, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 0);

    // Byte store into lane 2 of word 5, then signed/unsigned byte loads.
    mem[5] = 32'h11223344;
    transact("st_byte", 1'b1, 2'b00, 9'h016, 32'h000000AA, 1'b0, 32'h0, 1'b0, 1);
    check("st_byte_mem", mem[5], 32'h11AA3344);
    transact("ld_byte_s", 1'b0, 2'b00, 9'h016, 32'h0, 1'b0, 32'hFFFFFFAA, 1'b0, 0);
    transact("ld_byte_u", 1'b0, 2'b00, 9'h016, 32'h0, 1'b1, 32'h000000AA, 1'b0, 0);

    // Upper half loads.
    mem[5] = 32'h80001234;
    transact("ld_half_s", 1'b0, 2'b01, 9'h016, 32'h0, 1'b0, 32'hFFFF8000, 1'b0, 0);
    transact("ld_half_u", 1'b0, 2'b01, 9'h016, 32'h0, 1'b1, 32'h00008000, 1'b0, 0);

    // Half store ignores upper wdata bits; byte 1 readback; size 11 acts as word.
    transact("st_half", 1'b1, 2'b01, 9'h012, 32'hFFFF5678, 1'b0, 32'h0, 1'b0, 1);
    check("st_half_mem", mem[4], 32'h5678BEEF);
    transact("ld_byte1", 1'b0, 2'b00, 9'h011, 32'h0, 1'b0, 32'hFFFFFFBE, 1'b0, 0);
    transact("ld_sz11", 1'b0, 2'b11, 9'h010, 32'h0, 1'b0, 32'h5678BEEF, 1'b0, 0);

    // Misaligned accesses.
    mem[4] = 32'h01020304;
`ifdef MAU_MISALIGN_TRAP_EN
    transact("st_mis", 1'b1, 2'b10, 9'h013, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 0);
    check("st_mis_mem", mem[4], 32'h01020304);
    transact("ld_mis", 1'b0, 2'b01, 9'h017, 32'h0, 1'b0, 32'h0, 1'b1, 0);
`else
    transact("st_mis", 1'b1, 2'b10, 9'h013, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1);
    check("st_mis_mem", mem[4], 32'hCAFEF00D);
    transact("ld_mis", 1'b0, 2'b01, 9'h017, 32'h0, 1'b0, 32'hFFFF8000, 1'b0, 0);
`endif

    // Backpressure: response held for 5 cycles; no accept on the completing edge.
    mem[7] = 32'hA5A55A5A;
    @(negedge clk);
    drive_req(1'b0, 2'b10, 9'h01C, 32'h0, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_resp_valid", resp_valid, 1);
    held = resp_rdata;
    check("bp_rdata", held, 32'hA5A55A5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_rdata", resp_rdata, held);
      check("bp_hold_ready", req_ready, 0);
    end
    drive_req(1'b0, 2'b00, 9'h01F, 32'h0, 1'b1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp_no_accept", req_ready, 1);
    check("bp_resp_gone", resp_valid, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_accepted", req_ready, 0);
    repeat (2) @(negedge clk);
    check("bp2_resp_valid", resp_valid, 1);
    check("bp2_rdata", resp_rdata, 32'h000000A5);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Reset asserted while a store is in ACCESS.
    mem[6] = 32'h12345678;
    @(negedge clk);
    drive_req(1'b1, 2'b10, 9'h018, 32'hFFFFFFFF, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rsta_we_before", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rsta_we", mem_we, 0);
    check("rsta_req_ready", req_ready, 1);
    check("rsta_resp_valid", resp_valid, 0);
    check("rsta_rdata", resp_rdata, 0);
    check("rsta_err", resp_err, 0);
    check("rsta_mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rsta_mem", mem[6], 32'h12345678);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_we) seen = 1'b1;
    end
    check("rsta_no_resp", seen, 0);
    check("rsta_idle", req_ready, 1);
    check("rsta_mem_after", mem[6], 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
